// File: rtl/spi_loader_rx_if.sv
// Signal bundle between the serial program loader and its receive block.
// The master side drives the serial link and halt level; the slave side returns strobes and status.
interface spi_loader_rx_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mosi_in;
    logic [1:0]        mode_in;
    logic              proc_halt_in;
    logic              imem_we_out;
    logic              dmem_we_out;
    logic [ADDR_W-1:0] mem_waddr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic              run_out;
    logic              done_out;
    logic              frame_err_out;

    modport master (
        output mosi_in,
        output mode_in,
        output proc_halt_in,
        input  imem_we_out,
        input  dmem_we_out,
        input  mem_waddr_out,
        input  mem_wdata_out,
        input  run_out,
        input  done_out,
        input  frame_err_out
    );

    modport slave (
        input  mosi_in,
        input  mode_in,
        input  proc_halt_in,
        output imem_we_out,
        output dmem_we_out,
        output mem_waddr_out,
        output mem_wdata_out,
        output run_out,
        output done_out,
        output frame_err_out
    );
endinterface

// File: rtl/spi_loader_rx.sv
// Receive side of the serial program-loading link: deserialises {byte, addr} frames into
// one-cycle memory write strobes, gates processor execution in RUN and acknowledges halt.
module spi_loader_rx #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    spi_loader_rx_if.slave bus
);
    localparam int FRAME_W = DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RX_I = 2'b01,
        ST_RX_D = 2'b10,
        ST_RUN  = 2'b11
    } state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_imem_we;
    logic               r_dmem_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_run;
    logic               r_done;
    logic               r_err;

    state_t             w_state_next;
    logic [FRAME_W-1:0] w_sr_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_imem_we_next;
    logic               w_dmem_we_next;
    logic [ADDR_W-1:0]  w_waddr_next;
    logic [DATA_W-1:0]  w_wdata_next;
    logic               w_run_next;
    logic               w_done_next;
    logic               w_err_next;
    logic               w_enter;

    state_t             w_mode_state;
    logic [FRAME_W-1:0] w_shift;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_frame_full;
    logic               w_halt_seen;

    // mode encoding maps one-to-one onto the state encoding
    assign w_mode_state = state_t'(bus.mode_in);
    assign w_shift      = {bus.mosi_in, r_sr[FRAME_W-1:1]};
    assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_frame_full = (r_cnt >= CNT_W'(FRAME_W));
    assign w_halt_seen  = r_done | bus.proc_halt_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sr      <= w_sr_next;
            r_cnt     <= w_cnt_next;
            r_imem_we <= w_imem_we_next;
            r_dmem_we <= w_dmem_we_next;
            r_waddr   <= w_waddr_next;
            r_wdata   <= w_wdata_next;
            r_run     <= w_run_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_cnt_next     = r_cnt;
        w_imem_we_next = 1'b0;
        w_dmem_we_next = 1'b0;
        w_waddr_next   = r_waddr;
        w_wdata_next   = r_wdata;
        w_run_next     = 1'b0;
        w_done_next    = 1'b0;
        w_err_next     = r_err;
        w_enter        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_next = w_mode_state;
                w_enter      = 1'b1;
            end
            ST_RX_I, ST_RX_D: begin
                if (w_mode_state == r_state) begin
                    w_sr_next  = w_shift;
                    w_cnt_next = w_cnt_inc;
                end else if (w_mode_state == ST_IDLE) begin
                    // gap: the last FRAME_W samples are the frame, older lead-in has shifted out
                    if (w_frame_full) begin
                        w_imem_we_next = (r_state == ST_RX_I);
                        w_dmem_we_next = (r_state == ST_RX_D);
                        w_waddr_next   = r_sr[ADDR_W-1:0];
                        w_wdata_next   = r_sr[FRAME_W-1:ADDR_W];
                    end else begin
                        w_err_next = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end else begin
                    w_err_next   = 1'b1;
                    w_state_next = w_mode_state;
                    w_enter      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_mode_state == ST_RUN) begin
                    w_done_next = w_halt_seen;
                    w_run_next  = ~w_halt_seen;
                end else begin
                    w_state_next = w_mode_state;
                    w_enter      = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // the edge that enters a receive state already carries the first sample
        if (w_enter) begin
            case (w_state_next)
                ST_RX_I, ST_RX_D: begin
                    w_sr_next  = w_shift;
                    w_cnt_next = CNT_W'(1);
                end
                ST_RUN: begin
                    w_run_next = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.imem_we_out   = r_imem_we;
    assign bus.dmem_we_out   = r_dmem_we;
    assign bus.mem_waddr_out = r_waddr;
    assign bus.mem_wdata_out = r_wdata;
    assign bus.run_out       = r_run;
    assign bus.done_out      = r_done;
    assign bus.frame_err_out = r_err;
endmodule

// File: tb/tb_spi_loader_rx.sv
// Directed bench for spi_loader_rx: serial frames, back-to-back loads, run/halt handshake,
// malformed frames, mid-frame abort and asynchronous reset.
module tb_spi_loader_rx;
    logic clk;
    logic rst;

    spi_loader_rx_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    spi_loader_rx #(.DATA_W(8), .ADDR_W(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [12:0] obs_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // capture every strobe as {is_imem, addr, data}
    always @(negedge clk) begin
        if (bus.imem_we_out || bus.dmem_we_out) begin
            check("single strobe", 32'(bus.imem_we_out & bus.dmem_we_out), 32'd0);
            obs_q.push_back({bus.imem_we_out, bus.mem_waddr_out, bus.mem_wdata_out});
        end
    end

    task automatic tick(input logic [1:0] m, input logic d, input logic h);
        @(negedge clk);
        bus.mode_in      = m;
        bus.mosi_in      = d;
        bus.proc_halt_in = h;
    endtask

    task automatic send_frame(input logic [1:0] kind, input logic [11:0] val, input int lead);
        for (int i = 0; i < lead; i++) tick(kind, val[0], 1'b0);
        for (int i = 0; i < 12; i++) tick(kind, val[i], 1'b0);
        tick(2'b00, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(2'b00, 1'b0, 1'b0);
    endtask

    task automatic expect_wr(input string tag, input logic is_imem, input logic [3:0] addr,
                             input logic [7:0] data);
        logic [12:0] e;
        if (obs_q.size() == 0) begin
            check({tag, " present"}, 32'd0, 32'd1);
        end else begin
            e = obs_q.pop_front();
            check({tag, " kind"}, 32'(e[12]), 32'(is_imem));
            check({tag, " addr"}, 32'(e[11:8]), 32'(addr));
            check({tag, " data"}, 32'(e[7:0]), 32'(data));
        end
    endtask

    task automatic expect_none(input string tag);
        check(tag, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    int run_cnt;
    logic [7:0] dval;

    initial begin
        rst              = 1'b0;
        bus.mosi_in      = 1'b0;
        bus.mode_in      = 2'b00;
        bus.proc_halt_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst imem_we", 32'(bus.imem_we_out), 32'd0);
        check("rst dmem_we", 32'(bus.dmem_we_out), 32'd0);
        check("rst waddr", 32'(bus.mem_waddr_out), 32'd0);
        check("rst wdata", 32'(bus.mem_wdata_out), 32'd0);
        check("rst run", 32'(bus.run_out), 32'd0);
        check("rst done", 32'(bus.done_out), 32'd0);
        check("rst err", 32'(bus.frame_err_out), 32'd0);
        rst = 1'b1;
        idle(2);

        // 1: 0xA53 with bit0 sent three times
        send_frame(2'b01, 12'hA53, 2);
        idle(2);
        expect_wr("t1", 1'b1, 4'h3, 8'hA5);
        expect_none("t1 extra");
        check("t1 err", 32'(bus.frame_err_out), 32'd0);
        check("t1 waddr hold", 32'(bus.mem_waddr_out), 32'h3);
        check("t1 wdata hold", 32'(bus.mem_wdata_out), 32'hA5);

        // long frame saturates the counter and still commits
        send_frame(2'b10, 12'h2D8, 25);
        idle(2);
        expect_wr("sat", 1'b0, 4'h8, 8'h2D);
        check("sat err", 32'(bus.frame_err_out), 32'd0);

        // 2: sixteen back-to-back dmem frames, single-cycle gaps
        for (int a = 0; a < 16; a++) begin
            dval = 8'(a) ^ 8'h5A;
            send_frame(2'b10, {dval, 4'(a)}, 0);
        end
        idle(2);
        check("t2 count", 32'(obs_q.size()), 32'd16);
        for (int a = 0; a < 16; a++) begin
            dval = 8'(a) ^ 8'h5A;
            expect_wr($sformatf("t2 a%0d", a), 1'b0, 4'(a), dval);
        end
        expect_none("t2 extra");

        // 3: run for 20 cycles, then halt
        run_cnt = 0;
        tick(2'b11, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            tick(2'b11, 1'b0, 1'b0);
            run_cnt += int'(bus.run_out);
        end
        tick(2'b11, 1'b0, 1'b1);
        run_cnt += int'(bus.run_out);
        check("t3 done before halt", 32'(bus.done_out), 32'd0);
        tick(2'b11, 1'b0, 1'b1);
        check("t3 run cycles", 32'(run_cnt), 32'd20);
        check("t3 run off", 32'(bus.run_out), 32'd0);
        check("t3 done on", 32'(bus.done_out), 32'd1);
        tick(2'b11, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0);
        check("t3 done hold", 32'(bus.done_out), 32'd1);
        check("t3 run stays off", 32'(bus.run_out), 32'd0);
        tick(2'b01, 1'b1, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        check("t3 done drop", 32'(bus.done_out), 32'd0);
        check("t3 run drop", 32'(bus.run_out), 32'd0);
        send_frame(2'b01, 12'h3C7, 0);
        idle(2);
        expect_wr("t3 frame", 1'b1, 4'h7, 8'h3C);
        check("t3 err", 32'(bus.frame_err_out), 32'd0);
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b0, 1'b0);
        check("t3 halt ignored", 32'(bus.done_out), 32'd0);
        expect_none("t3 extra");

        // 4: short frame (7 samples) is dropped and flagged
        for (int i = 0; i < 7; i++) tick(2'b01, 1'b1, 1'b0);
        idle(3);
        expect_none("t4 no strobe");
        check("t4 err set", 32'(bus.frame_err_out), 32'd1);
        send_frame(2'b10, 12'h5F0, 0);
        idle(2);
        expect_wr("t4 good", 1'b0, 4'h0, 8'h5F);
        check("t4 err sticky", 32'(bus.frame_err_out), 32'd1);

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 7; i++) tick(2'b01, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("t6 err", 32'(bus.frame_err_out), 32'd0);
        check("t6 waddr", 32'(bus.mem_waddr_out), 32'd0);
        check("t6 wdata", 32'(bus.mem_wdata_out), 32'd0);
        check("t6 run", 32'(bus.run_out), 32'd0);
        check("t6 done", 32'(bus.done_out), 32'd0);
        bus.mode_in = 2'b00;
        bus.mosi_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(2'b01, 12'h9B4, 0);
        idle(2);
        expect_wr("t6 fresh", 1'b1, 4'h4, 8'h9B);
        check("t6 err clean", 32'(bus.frame_err_out), 32'd0);
        expect_none("t6 extra");

        // 5: imem frame switched to dmem mid-way
        for (int i = 0; i < 5; i++) tick(2'b01, 1'b0, 1'b0);
        send_frame(2'b10, 12'h6E1, 0);
        idle(2);
        expect_wr("t5 dmem", 1'b0, 4'h1, 8'h6E);
        check("t5 err", 32'(bus.frame_err_out), 32'd1);
        expect_none("t5 extra");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
